// File: rtl/capped_diff_if.sv
// Bus between the gradient unit and the capped-difference stage.
// The master drives the operands; the slave (capped_diff_top) returns the
// registered, saturated result and its clamp flags.
interface capped_diff_if;
  logic        in_valid;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic [15:0] next_val;
  logic        overflow;
  logic        underflow_q;

  modport master (
    output in_valid, a_in, b_in,
    input  out_valid, next_val, overflow, underflow_q
  );

  modport slave (
    input  in_valid, a_in, b_in,
    output out_valid, next_val, overflow, underflow_q
  );
endinterface

// File: rtl/capped_diff_top.sv
// Saturating gradient-descent update stage: next_val = a_in - LR * b_in in
// signed Q8.8, clamped to the Q8.8 range, with per-sample overflow/underflow
// flags. One cycle of latency, no backpressure.
// Optional build macro CAPPED_DIFF_ROUND_EN: round the scaled step half up
// instead of truncating toward -inf.
module capped_diff_top #(
  parameter logic signed [15:0] LR    = 16'sh0100,
  parameter int unsigned        WIDTH = 16          // only 16 (Q8.8) is supported
) (
  input logic            clk,
  input logic            rst_n,
  capped_diff_if.slave   bus
);

  localparam int unsigned ProdW = 2 * WIDTH;

  localparam logic signed [ProdW-1:0] MaxPos = 32'sd32767;
  localparam logic signed [ProdW-1:0] MinNeg = -32'sd32768;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] prod_adj;
  logic signed [ProdW-1:0] step;
  logic signed [ProdW-1:0] diff;

  logic [WIDTH-1:0] sat_val;
  logic             sat_ov;
  logic             sat_un;

  logic [WIDTH-1:0] next_val_q;
  logic             overflow_q;
  logic             underflow_qq;
  logic             out_valid_q;

  assign a_s = bus.a_in;
  assign b_s = bus.b_in;

  // Scale the gradient by LR, then compute the unclamped difference.
  // |step| < 2^23, so a 32-bit difference can never wrap.
  always_comb begin
    prod = b_s * LR;
`ifdef CAPPED_DIFF_ROUND_EN
    prod_adj = prod + 32'sh80;
`else
    prod_adj = prod;
`endif
    step = prod_adj >>> 8;
    diff = a_s - step;
  end

  // Clamp to the Q8.8 range; the two end points themselves are not flagged.
  always_comb begin
    sat_val = diff[WIDTH-1:0];
    sat_ov  = 1'b0;
    sat_un  = 1'b0;
    if (diff > MaxPos) begin
      sat_val = 16'h7FFF;
      sat_ov  = 1'b1;
    end else if (diff < MinNeg) begin
      sat_val = 16'h8000;
      sat_un  = 1'b1;
    end
  end

  // Output register: capture on valid, hold otherwise; out_valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_val_q   <= '0;
      overflow_q   <= 1'b0;
      underflow_qq <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        next_val_q   <= sat_val;
        overflow_q   <= sat_ov;
        underflow_qq <= sat_un;
      end
    end
  end

  assign bus.next_val    = next_val_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow_q = underflow_qq;
  assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_capped_diff_top.sv
// Bench for capped_diff_top: two instances (LR = 1.0 and LR = 0.5) share the
// same stimulus; an integer-arithmetic model is compared on every negedge,
// plus hand-computed literal expectations at key points.
module tb_capped_diff_top;

  typedef struct packed {
    logic [15:0] nv;
    logic        ov;
    logic        un;
    logic        vld;
  } res_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  capped_diff_if bus0 ();
  capped_diff_if bus1 ();

  capped_diff_top #(.LR(16'sh0100)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  capped_diff_top #(.LR(16'sh0080)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1, "watchdog");
  end

  function automatic int floor_div256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  // Result of one sample, straight from the arithmetic definition.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input int lr);
    res_t r;
    int   av, bv, prod, step, diff;
    av   = int'($signed(a));
    bv   = int'($signed(b));
    prod = bv * lr;
`ifdef CAPPED_DIFF_ROUND_EN
    prod = prod + 128;
`endif
    step  = floor_div256(prod);
    diff  = av - step;
    r.vld = 1'b1;
    r.ov  = 1'b0;
    r.un  = 1'b0;
    if (diff > 32767) begin
      r.nv = 16'h7FFF;
      r.ov = 1'b1;
    end else if (diff < -32768) begin
      r.nv = 16'h8000;
      r.un = 1'b1;
    end else begin
      r.nv = 16'(diff);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, need %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs of each instance.
  res_t exp0, exp1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp0 <= '0;
      exp1 <= '0;
    end else begin
      exp0.vld <= bus0.in_valid;
      exp1.vld <= bus1.in_valid;
      if (bus0.in_valid) begin
        exp0.nv <= model(bus0.a_in, bus0.b_in, 256).nv;
        exp0.ov <= model(bus0.a_in, bus0.b_in, 256).ov;
        exp0.un <= model(bus0.a_in, bus0.b_in, 256).un;
      end
      if (bus1.in_valid) begin
        exp1.nv <= model(bus1.a_in, bus1.b_in, 128).nv;
        exp1.ov <= model(bus1.a_in, bus1.b_in, 128).ov;
        exp1.un <= model(bus1.a_in, bus1.b_in, 128).un;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("m0_val", 32'(bus0.next_val), 32'(exp0.nv));
    check("m0_ovf", 32'(bus0.overflow), 32'(exp0.ov));
    check("m0_unf", 32'(bus0.underflow_q), 32'(exp0.un));
    check("m0_vld", 32'(bus0.out_valid), 32'(exp0.vld));
    check("m1_val", 32'(bus1.next_val), 32'(exp1.nv));
    check("m1_ovf", 32'(bus1.overflow), 32'(exp1.ov));
    check("m1_unf", 32'(bus1.underflow_q), 32'(exp1.un));
    check("m1_vld", 32'(bus1.out_valid), 32'(exp1.vld));
  end

  // Present one valid sample to both instances, then step to just after the edge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b);
    bus0.in_valid = 1'b1; bus0.a_in = a; bus0.b_in = b;
    bus1.in_valid = 1'b1; bus1.a_in = a; bus1.b_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Literal check of instance 0 (LR = 1.0) outputs.
  task automatic lit0(input string name, input logic [15:0] nv, input logic ov,
                      input logic un, input logic vld);
    check({name, "_val"}, 32'(bus0.next_val), 32'(nv));
    check({name, "_ovf"}, 32'(bus0.overflow), 32'(ov));
    check({name, "_unf"}, 32'(bus0.underflow_q), 32'(un));
    check({name, "_vld"}, 32'(bus0.out_valid), 32'(vld));
  endtask

  logic [15:0] sa, sb;

  initial begin
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.a_in = '0; bus0.b_in = '0;
    bus1.in_valid = 1'b0; bus1.a_in = '0; bus1.b_in = '0;
    #1;
    lit0("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("reset1_val", 32'(bus1.next_val), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic function and boundaries at LR = 1.0
    apply(16'h0000, 16'h0000); lit0("zero", 16'h0000, 1'b0, 1'b0, 1'b1);
    apply(16'hE000, 16'h2000); lit0("neg64", 16'hC000, 1'b0, 1'b0, 1'b1);
    apply(16'hC000, 16'h4000); lit0("minexact", 16'h8000, 1'b0, 1'b0, 1'b1);
    apply(16'hA000, 16'h6000); lit0("under", 16'h8000, 1'b0, 1'b1, 1'b1);
    apply(16'h7000, 16'h9000); lit0("over", 16'h7FFF, 1'b1, 1'b0, 1'b1);
    apply(16'h4000, 16'hC001); lit0("maxexact", 16'h7FFF, 1'b0, 1'b0, 1'b1);

    // LR = 0.5 instance: half step, then sub-LSB step
    apply(16'h0100, 16'h0100);
    check("half_val", 32'(bus1.next_val), 32'h0080);
    apply(16'h0100, 16'h0001);
`ifdef CAPPED_DIFF_ROUND_EN
    check("tiny_val", 32'(bus1.next_val), 32'h00FF);
`else
    check("tiny_val", 32'(bus1.next_val), 32'h0100);
`endif

    // Back-to-back stream with 16-bit wrap of a and b
    sa = 16'h0000;
    sb = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      apply(sa, sb);
      sa = sa - 16'h2000;
      sb = sb + 16'h2000;
    end
    lit0("stream_last", 16'hC000, 1'b0, 1'b0, 1'b1);

    // Gap holds value and flags; next in-range sample clears flags
    apply(16'h7000, 16'h9000);
    idle();
    idle();
    lit0("hold", 16'h7FFF, 1'b1, 1'b0, 1'b0);
    apply(16'h0100, 16'h0000); lit0("clear", 16'h0100, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream, between clock edges
    apply(16'h1000, 16'h0800);
    #2 rst_n = 1'b0;
    #1;
    lit0("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("async_rst1_val", 32'(bus1.next_val), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(16'h0300, 16'h0100); lit0("post_rst", 16'h0200, 1'b0, 1'b0, 1'b1);
    idle();
    lit0("post_idle", 16'h0200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
